demux_dist: RTL

- Registered 1-to-4 demultiplexer/distributor: the inverse of the four-input mux (A/B/C/D, sel).
- Accepts one input stream of data+sel beats over a valid/ready handshake.
- Routes each beat to one of four output channels (A, B, C, D), each buffered by a small FIFO with its own valid/ready handshake.
- Sits downstream of the mux path in the mux_alu environment and fans one producer out to four consumers.

---
 rtl/demux_dist.sv | 102 ++++++++++
 1 files changed

// File: rtl/demux_dist.sv
// Registered 1-to-4 distributor: one valid/ready input stream fanned out to four
// independent per-channel FIFOs, each with its own valid/ready output handshake.
module demux_dist #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [15:0]      acc_cnt,
    output logic [3:0]       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem   [4][DEPTH];
    logic [PW-1:0]    r_wptr  [4];
    logic [PW-1:0]    r_rptr  [4];
    logic [CW-1:0]    r_count [4];
    logic [WIDTH-1:0] r_head  [4];
    logic [15:0]      r_acc;

    logic             w_accept;
    logic [3:0]       w_push;
    logic [3:0]       w_pop;
    logic [CW-1:0]    w_remain    [4];
    logic [CW-1:0]    w_nextCount [4];
    logic [PW-1:0]    w_headIdx   [4];
    logic [WIDTH-1:0] w_nextHead  [4];

    always_comb begin
        full      = 4'b0;
        out_valid = 4'b0;
        for (int ch = 0; ch < 4; ch++) begin
            full[ch]      = (r_count[ch] == CW'(DEPTH));
            out_valid[ch] = (r_count[ch] != '0);
        end
    end

    // No pop-through: a full channel refuses a push even if it drains this cycle.
    assign in_ready = ~rst & ~full[in_sel];
    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept ? (4'b0001 << in_sel) : 4'b0000;
    assign w_pop    = out_valid & out_ready;

    // If the channel is left with nothing but the incoming beat, that beat is the new head.
    always_comb begin
        for (int ch = 0; ch < 4; ch++) begin
            w_remain[ch]    = r_count[ch] - CW'(w_pop[ch]);
            w_nextCount[ch] = w_remain[ch] + CW'(w_push[ch]);
            w_headIdx[ch]   = r_rptr[ch] + PW'(w_pop[ch]);
            w_nextHead[ch]  = (w_remain[ch] == '0) ? in_data : r_mem[ch][w_headIdx[ch]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            for (int ch = 0; ch < 4; ch++) begin
                r_wptr[ch]  <= '0;
                r_rptr[ch]  <= '0;
                r_count[ch] <= '0;
                r_head[ch]  <= '0;
            end
        end else begin
            if (w_accept) begin
                r_acc <= r_acc + 16'd1;
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (w_push[ch]) begin
                    r_mem[ch][r_wptr[ch]] <= in_data;
                    r_wptr[ch]            <= r_wptr[ch] + PW'(1);
                end
                if (w_pop[ch]) begin
                    r_rptr[ch] <= r_rptr[ch] + PW'(1);
                end
                r_count[ch] <= w_nextCount[ch];
                // An emptied channel keeps showing its last head value.
                if (w_nextCount[ch] != '0) begin
                    r_head[ch] <= w_nextHead[ch];
                end
            end
        end
    end

    assign A       = r_head[0];
    assign B       = r_head[1];
    assign C       = r_head[2];
    assign D       = r_head[3];
    assign acc_cnt = r_acc;

endmodule
